ex_result_stage: RTL
====================

// Module: ex_result_stage
// PURPOSE
//  EX->MEM boundary stage directly downstream of the ALU. Captures ALUResult/Zero/Negative plus
//  control, resolves branches/jumps, selects the writeback value and buffers it in a 2-entry skid
//  buffer with valid/ready handshaking, so MEM back-pressure never combinationally reaches the ALU.
// PARAMETERS
//  XLEN     32  datapath width
//  REG_AW   5   register-address width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       upstream EX bundle valid
//  in_ready     out  1       stage can accept; registered (== state!=TWO)
//  ALUResult    in   XLEN    ALU output
//  Zero         in   1       ALU zero flag
//  Negative     in   1       ALU sign flag
//  BranchType   in   3       0 none,1 beq,2 bne,3 blt,4 bge,5 jump(jal/jalr); 6,7 treated as none
//  PCTarget     in   XLEN    branch/jump target
//  PCPlus4      in   XLEN    link value
//  ResultSrc    in   2       00 ALU, 01 memory load, 10 PCPlus4, 11 treated as 00
//  RegWrite     in   1       writeback enable
//  Rd           in   REG_AW  destination register
//  WriteData    in   XLEN    store data (rs2)
//  flush        in   1       discard all buffered entries
//  out_valid    out  1       head entry valid
//  out_ready    in   1       MEM accepts head
//  MemAddr      out  XLEN    head ALUResult
//  Result       out  XLEN    head writeback value (PCPlus4 if ResultSrc==10, else ALUResult)
//  MemRead/MemWrite out 1    head ResultSrc==01 / head store flag (BranchType==0,RegWrite==0,ResultSrc==01)
//  RegWriteOut  out  1       head RegWrite; RdOut out REG_AW head Rd; WriteDataOut out XLEN
//  Redirect     out  1       one-cycle pulse: accepted bundle was a taken branch/jump
//  RedirectPC   out  XLEN    target accompanying Redirect, holds until next Redirect
// BEHAVIOUR
//  - Reset: state EMPTY, out_valid=0, in_ready=1, Redirect=0, RedirectPC=0, all payload regs 0.
//  - Accept = in_valid & in_ready; Pop = out_valid & out_ready. Outputs driven from head register.
//  - FSM EMPTY/ONE/TWO: EMPTY+acc->ONE; ONE+acc&!pop->TWO; ONE+pop&!acc->EMPTY; ONE+acc&pop->ONE
//    (new entry becomes head); TWO+pop->ONE (skid entry moves to head); TWO never accepts.
//  - Latency: accepted bundle visible on outputs the next cycle when buffer was EMPTY, or
//    after head pops otherwise. Order strictly FIFO; no entry dropped or duplicated.
//  - Taken: beq Zero; bne !Zero; blt !Zero (ALU did slt); bge !Zero (ALU did >= compare);
//    jump always; none/6/7 never. Negative is captured only for the perf feature.
//  - Redirect registered: asserted the cycle after an accepted taken bundle, for exactly 1 cycle.
//  - flush: next state EMPTY, out_valid=0 next cycle, same-cycle accept ignored, Redirect for a
//    same-cycle accept suppressed; an already-scheduled Redirect pulse still fires.
//  - Pop while flush: pop ignored (entry discarded by flush). No X on outputs while out_valid=0.
//  - Async reset mid-transfer: all entries lost immediately, reset values above.
// CONFIGURATION
//  EX_PERF_CNT_EN defined: adds outputs BranchCount, TakenCount, NegCount (32b each, reset 0,
//    saturate at 32'hFFFF_FFFF); increment on accept of a conditional branch (types 1-4), a taken
//    bundle, and an accepted bundle with Negative=1 respectively; flush does not clear them.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, Redirect=0 immediately.
//  2 out_ready=1, 3 ALU ops (5,7,9) back-to-back -> Result 5,7,9 on consecutive cycles, 1-cycle lat.
//  3 out_ready=0, push 3 bundles -> first two held, in_ready=0 after 2nd; release -> order 1,2,3.
//  4 beq Zero=1 PCTarget=0x40 -> Redirect=1 one cycle later, RedirectPC=0x40; bne Zero=1 -> none.
//  5 jal ResultSrc=10 PCPlus4=0x104 -> Result=0x104, Redirect=1; flush same cycle -> no Redirect.
//  6 EX_PERF_CNT_EN: 4 branches, 2 taken, 1 Negative -> BranchCount=4, TakenCount=2, NegCount=1.

Source files
------------

// File: rtl/ex_result_stage.sv
// ex_result_stage
//   EX->MEM boundary stage. It captures the ALU result and its control bundle,
//   resolves branches and jumps, and selects the writeback value. Entries are
//   held in a 2-entry skid buffer, so MEM back-pressure (out_ready) never
//   reaches in_ready combinationally.
//
//   Ports:
//     clk, rst_n          clock; asynchronous active-low reset
//     in_valid/in_ready   upstream handshake (in_ready depends on state only)
//     ALUResult, Zero, Negative, BranchType, PCTarget, PCPlus4,
//     ResultSrc, RegWrite, Rd, WriteData   EX bundle
//     flush               discards all buffered entries
//     out_valid/out_ready downstream handshake for the head entry
//     MemAddr, Result, MemRead, MemWrite, RegWriteOut, RdOut, WriteDataOut
//                         head entry payload
//     Redirect/RedirectPC one-cycle taken-branch pulse and its held target
//
//   Optional build macro EX_PERF_CNT_EN adds the saturating counters
//   BranchCount, TakenCount and NegCount.
module ex_result_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   ALUResult,
  input  logic              Zero,
  input  logic              Negative,
  input  logic [2:0]        BranchType,
  input  logic [XLEN-1:0]   PCTarget,
  input  logic [XLEN-1:0]   PCPlus4,
  input  logic [1:0]        ResultSrc,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] Rd,
  input  logic [XLEN-1:0]   WriteData,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   MemAddr,
  output logic [XLEN-1:0]   Result,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              RegWriteOut,
  output logic [REG_AW-1:0] RdOut,
  output logic [XLEN-1:0]   WriteDataOut,
  output logic              Redirect,
`ifdef EX_PERF_CNT_EN
  output logic [31:0]       BranchCount,
  output logic [31:0]       TakenCount,
  output logic [31:0]       NegCount,
`endif
  output logic [XLEN-1:0]   RedirectPC
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   result;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } entry_t;

  state_t state, state_next;
  entry_t head, skid, new_entry;
  logic   accept, pop, taken;
  logic   load_head, load_skid, shift_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_entry           = '0;
    new_entry.addr      = ALUResult;
    new_entry.result    = (ResultSrc == 2'b10) ? PCPlus4 : ALUResult;
    new_entry.mem_read  = (ResultSrc == 2'b01);
    new_entry.mem_write = (BranchType == 3'd0) && !RegWrite && (ResultSrc == 2'b01);
    new_entry.reg_write = RegWrite;
    new_entry.rd        = Rd;
    new_entry.wdata     = WriteData;
  end

  // blt/bge rely on the ALU having produced slt / >= so that Zero == !taken.
  always_comb begin
    taken = 1'b0;
    case (BranchType)
      3'd1:    taken = Zero;
      3'd2,
      3'd3,
      3'd4:    taken = !Zero;
      3'd5:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // flush overrides both the accept and the pop in the same cycle.
  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_head  = 1'b1;
          state_next = ONE;
        end
        ONE: begin
          if (accept && !pop) begin
            load_skid  = 1'b1;
            state_next = TWO;
          end else if (!accept && pop) begin
            state_next = EMPTY;
          end else if (accept && pop) begin
            load_head  = 1'b1;
          end
        end
        TWO: if (pop) begin
          shift_skid = 1'b1;
          state_next = ONE;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head)  head <= new_entry;
      if (load_skid)  skid <= new_entry;
      if (shift_skid) head <= skid;
    end
  end

  assign MemAddr      = head.addr;
  assign Result       = head.result;
  assign MemRead      = head.mem_read;
  assign MemWrite     = head.mem_write;
  assign RegWriteOut  = head.reg_write;
  assign RdOut        = head.rd;
  assign WriteDataOut = head.wdata;

  // A pulse scheduled in the previous cycle still fires under flush; only a
  // same-cycle accept is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Redirect   <= 1'b0;
      RedirectPC <= '0;
    end else begin
      Redirect <= accept & taken & !flush;
      if (accept && taken && !flush) RedirectPC <= PCTarget;
    end
  end

`ifdef EX_PERF_CNT_EN
  logic count_en, is_cond;
  assign count_en = accept & !flush;
  assign is_cond  = (BranchType >= 3'd1) && (BranchType <= 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount <= '0;
      TakenCount  <= '0;
      NegCount    <= '0;
    end else if (count_en) begin
      if (is_cond  && BranchCount != '1) BranchCount <= BranchCount + 32'd1;
      if (taken    && TakenCount  != '1) TakenCount  <= TakenCount + 32'd1;
      if (Negative && NegCount    != '1) NegCount    <= NegCount + 32'd1;
    end
  end
`else
  logic unused_negative;
  assign unused_negative = Negative;
`endif

endmodule
